hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
//   Pipeline hazard controller that drives the stall and flush inputs of the IF/ID and ID/EX
//   pipeline registers. It reads the decoded instruction in ID and the ID_EX stage outputs.
//   It inserts load-use bubbles of LOAD_STALL cycles, squashes wrong-path instructions on a
//   taken branch or jump, and keeps a saturating count of hazard stall cycles.
// PARAMETERS
//   INSTR_W     19    instruction width
//   RD_LSB      11    LSB of 3-bit destination field rd (instr[RD_LSB+2:RD_LSB])
//   RS_LSB      8     LSB of 3-bit source field rs
//   RT_LSB      5     LSB of 3-bit source field rt
//   MEM_SEL     2'b01 reg_write_mux code selecting memory read data (load)
//   LOAD_STALL  1     bubble cycles per load-use hazard, 1..7
// PORTS
//   clk                  in   1   clock, rising edge
//   reset                in   1   asynchronous, active-low reset
//   IF_ID_instruction    in   19  instruction currently in ID
//   ID_uses_rs           in   1   ID instruction reads rs
//   ID_uses_rt           in   1   ID instruction reads rt
//   ID_jump              in   1   ID instruction is an unconditional jump
//   ID_EX_instruction    in   19  instruction currently in EX
//   ID_EX_reg_write      in   1   EX instruction writes the register file
//   ID_EX_reg_write_mux  in   2   EX write-back source select
//   EX_branch_taken      in   1   branch resolved taken in EX this cycle
//   pc_write             out  1   PC may update
//   IF_ID_write          out  1   IF/ID may load
//   IF_ID_flush          out  1   clear IF/ID at next edge
//   ID_EX_flush          out  1   clear ID/EX at next edge (bubble)
//   stall_count          out  16  saturating count of hazard stall cycles
// BEHAVIOUR
//   - Outputs pc_write, IF_ID_write, IF_ID_flush and ID_EX_flush are combinational from state
//     and inputs. State, counter and stall_count are registers.
//   - While reset=0: state=RUN, cnt=0, stall_count=0. Outputs are forced to pc_write=0,
//     IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1.
//   - Default outputs: pc_write=1, IF_ID_write=1, both flushes 0.
//   - lu_hazard = ID_EX_reg_write & (ID_EX_reg_write_mux==MEM_SEL) &
//     ((ID_uses_rs & rs==ID_EX.rd) | (ID_uses_rt & rt==ID_EX.rd)). Register 0 is not
//     special-cased.
//   - Priority in every state: EX_branch_taken > lu_hazard > ID_jump.
//   - RUN state:
//       - EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1, pc_write=1. Stay in RUN.
//       - Else lu_hazard: pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_count++.
//         If LOAD_STALL>1, go to LSTALL with cnt=LOAD_STALL-1; otherwise stay in RUN.
//       - Else ID_jump: IF_ID_flush=1 only. Stay in RUN.
//   - LSTALL state:
//       - Outputs: pc_write=0, IF_ID_write=0, ID_EX_flush=1, stall_count++, cnt--.
//       - Return to RUN after the cycle in which cnt==1.
//       - lu_hazard is not re-evaluated in this state (EX holds a bubble).
//       - EX_branch_taken in LSTALL aborts the stall: apply the branch outputs, cnt=0,
//         go to RUN, no stall_count increment.
//   - Total load-use stall is exactly LOAD_STALL cycles.
//   - stall_count holds at 16'hFFFF and never wraps.
//   - Reset asserted mid-stall returns to RUN immediately. Releasing reset mid-cycle
//     causes no spurious stall.
// TESTING
//   - Reset: hold reset=0 for 3 cycles -> stall_count=0, IF_ID_flush=1, ID_EX_flush=1,
//     pc_write=0; release -> pc_write=1, flushes 0.
//   - Load-use: EX = load rd=3, ID reads rs=3, LOAD_STALL=1 -> one cycle of pc_write=0 and
//     ID_EX_flush=1, then normal; stall_count=1.
//   - No hazard: ID_uses_rs=0 with rs==rd=3, or ID_EX_reg_write_mux=2'b00 -> no stall,
//     stall_count unchanged.
//   - LOAD_STALL=3: stall lasts exactly 3 cycles (stall_count=3). EX_branch_taken in the
//     2nd stall cycle -> both flushes=1, pc_write=1, RUN next, stall_count=1.
//   - Branch+jump together: EX_branch_taken=1 and ID_jump=1 -> IF_ID_flush=1 and
//     ID_EX_flush=1. ID_jump alone -> IF_ID_flush=1, ID_EX_flush=0.
//   - Saturation: preload 16'hFFFE, force 3 stall cycles -> stall_count=16'hFFFF and holds.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Load-use stall / branch-jump squash controller for the IF/ID and ID/EX registers.
// Control outputs are combinational from state and inputs; state and stall_count are registered.
module hazard_control_unit #(
  parameter int         INSTR_W    = 19,
  parameter int         RD_LSB     = 11,
  parameter int         RS_LSB     = 8,
  parameter int         RT_LSB     = 5,
  parameter logic [1:0] MEM_SEL    = 2'b01,
  parameter int         LOAD_STALL = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] IF_ID_instruction,
  input  logic               ID_uses_rs,
  input  logic               ID_uses_rt,
  input  logic               ID_jump,
  input  logic [INSTR_W-1:0] ID_EX_instruction,
  input  logic               ID_EX_reg_write,
  input  logic [1:0]         ID_EX_reg_write_mux,
  input  logic               EX_branch_taken,
  output logic               pc_write,
  output logic               IF_ID_write,
  output logic               IF_ID_flush,
  output logic               ID_EX_flush,
  output logic [15:0]        stall_count
);

  typedef enum logic {RUN, LSTALL} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       stall_inc;
  logic       lu_hazard;

  logic [2:0] ex_rd, id_rs, id_rt;
  assign ex_rd = ID_EX_instruction[RD_LSB +: 3];
  assign id_rs = IF_ID_instruction[RS_LSB +: 3];
  assign id_rt = IF_ID_instruction[RT_LSB +: 3];

  assign lu_hazard = ID_EX_reg_write && (ID_EX_reg_write_mux == MEM_SEL) &&
                     ((ID_uses_rs && (id_rs == ex_rd)) || (ID_uses_rt && (id_rt == ex_rd)));

  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    stall_inc   = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    if (!reset) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (lu_hazard) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_STALL > 1) begin
              state_nxt = LSTALL;
              cnt_nxt   = CNT_INIT;
            end
          end else if (ID_jump) begin
            IF_ID_flush = 1'b1;
          end
        end
        LSTALL: begin
          // EX holds the bubble we inserted, so lu_hazard is not re-checked here.
          if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_nxt   = RUN;
            cnt_nxt     = 3'd0;
          end else begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            stall_inc   = 1'b1;
            cnt_nxt     = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cnt         <= 3'd0;
      stall_count <= 16'h0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule
